// File: rtl/bridge_stream_arbiter.sv
// Round-robin packet arbiter feeding a single combine bridge.
// One grant is held per packet; an optional beat cap forces a last_o so the
// downstream combiner never sees an unbounded packet. No data storage: the
// granted requester's valid/data/last pass straight through.
module bridge_stream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DIN_W     = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BEATS = 16,
    parameter int ID_W      = $clog2(N_REQ)
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [N_REQ-1:0]                         vld_i,
    input  logic [N_REQ-1:0][DIN_W-1:0][DATA_W-1:0]  din,
    input  logic [N_REQ-1:0]                         last_i,
    output logic [N_REQ-1:0]                         rdy_o,
    output logic                                     vld_o,
    output logic [DIN_W-1:0][DATA_W-1:0]             dout,
    output logic                                     last_o,
    input  logic                                     rdy_i,
    output logic [ID_W-1:0]                          src_id_o,
    output logic                                     trunc_o
);

    // Beat counter must hold 0..MAX_BEATS-1; keep at least one bit when the cap is off.
    localparam int CNT_W = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;
    localparam logic [CNT_W-1:0] CAP_VAL = CNT_W'((MAX_BEATS > 0) ? MAX_BEATS - 1 : 0);
    localparam int SUM_W = ID_W + 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [ID_W-1:0]        r_grant;
    logic [ID_W-1:0]        r_rr_ptr;
    logic [CNT_W-1:0]       r_beat_cnt;
    logic                   r_trunc;

    state_t                 w_state_next;
    logic [ID_W-1:0]        w_grant_next;
    logic [ID_W-1:0]        w_rr_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_trunc_next;

    logic                   w_busy;
    logic                   w_cap;
    logic                   w_any;
    logic [ID_W-1:0]        w_pick;
    logic [N_REQ-1:0][ID_W-1:0] w_cand;
    logic [N_REQ-1:0]       w_cand_vld;

    assign w_busy   = (r_state == S_BUSY);
    assign w_any    = |vld_i;
    assign src_id_o = r_grant;
    assign trunc_o  = r_trunc;

    // Candidate gi is the requester gi places after the round-robin pointer,
    // wrapped explicitly so non-power-of-two N_REQ works.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_scan
        logic [SUM_W-1:0] w_sum;
        assign w_sum          = {1'b0, r_rr_ptr} + SUM_W'(gi);
        assign w_cand[gi]     = (w_sum >= SUM_W'(N_REQ)) ? ID_W'(w_sum - SUM_W'(N_REQ))
                                                         : w_sum[ID_W-1:0];
        assign w_cand_vld[gi] = vld_i[w_cand[gi]];
    end

    // Only the granted requester sees the bridge's ready, and only while busy.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rdy
        assign rdy_o[gi] = w_busy && (r_grant == ID_W'(gi)) && rdy_i;
    end

    // Pick the first valid candidate in round-robin order (lowest offset wins).
    always_comb begin
        w_pick = w_cand[0];
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (w_cand_vld[i]) begin
                w_pick = w_cand[i];
            end
        end
    end

    // Next-state logic and output mux for the IDLE/BUSY grant machine.
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_rr_next    = r_rr_ptr;
        w_cnt_next   = r_beat_cnt;
        w_trunc_next = 1'b0;
        w_cap        = 1'b0;
        vld_o        = 1'b0;
        last_o       = 1'b0;
        dout         = din[r_grant];

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_grant_next = w_pick;
                    w_cnt_next   = '0;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                vld_o  = vld_i[r_grant];
                w_cap  = (MAX_BEATS != 0) && (r_beat_cnt == CAP_VAL);
                last_o = vld_o && (last_i[r_grant] || w_cap);
                if (vld_o && rdy_i) begin
                    if (last_o) begin
                        w_cnt_next   = '0;
                        w_rr_next    = (r_grant == ID_W'(N_REQ - 1)) ? '0
                                                                     : ID_W'(r_grant + 1'b1);
                        w_state_next = S_IDLE;
                        // A cut packet: the requester's remaining beats re-arbitrate later.
                        w_trunc_next = w_cap && !last_i[r_grant];
                    end else begin
                        w_cnt_next = r_beat_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any grant in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
            r_trunc    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_grant    <= w_grant_next;
            r_rr_ptr   <= w_rr_next;
            r_beat_cnt <= w_cnt_next;
            r_trunc    <= w_trunc_next;
        end
    end

endmodule

// File: tb/tb_bridge_stream_arbiter.sv
// Scoreboard bench for bridge_stream_arbiter (N_REQ=4, 64-bit beats, MAX_BEATS=16).
module tb_bridge_stream_arbiter;

    logic                   clk;
    logic                   rst_n;
    logic [3:0]             vld_i;
    logic [3:0][7:0][7:0]   din;
    logic [3:0]             last_i;
    logic [3:0]             rdy_o;
    logic                   vld_o;
    logic [7:0][7:0]        dout;
    logic                   last_o;
    logic                   rdy_i;
    logic [1:0]             src_id_o;
    logic                   trunc_o;

    bridge_stream_arbiter #(
        .N_REQ(4), .DIN_W(8), .DATA_W(8), .MAX_BEATS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vld_i(vld_i), .din(din), .last_i(last_i),
        .rdy_o(rdy_o), .vld_o(vld_o), .dout(dout), .last_o(last_o), .rdy_i(rdy_i),
        .src_id_o(src_id_o), .trunc_o(trunc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          src;
        logic [63:0] data;
        logic        last;
        logic        cut;
    } exp_t;

    exp_t        exp_q[$];
    logic [64:0] srcq[4][$];   // {last, data} per requester
    logic [3:0]  hold;
    logic        bp_mode;
    logic        force_stall;
    logic [3:0]  bp_pat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int first_acc;
    int last_acc;
    logic prev_last;
    logic chk_bubble;
    logic pend_trunc;
    logic prev_stall;
    logic [63:0] prev_dout;
    logic [1:0]  prev_src;
    logic s_vld;
    logic [1:0] s_src;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mk(input int k, input int p, input int b);
        return {8'(k), 8'(p), 8'(b), 40'h5AC3963CE1} ^ 64'(b * 37 + k * 11);
    endfunction

    task automatic src_pkt(input int k, input int p, input int n);
        for (int b = 0; b < n; b++) srcq[k].push_back({(b == n - 1), mk(k, p, b)});
    endtask

    task automatic exp_pkt(input int k, input int p, input int b0, input int b1,
                           input logic last_end, input logic cut);
        exp_t e;
        for (int b = b0; b <= b1; b++) begin
            e.src  = k;
            e.data = mk(k, p, b);
            e.last = (b == b1) && last_end;
            e.cut  = (b == b1) && cut;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive_inputs();
        logic [64:0] f;
        for (int k = 0; k < 4; k++) begin
            if (srcq[k].size() > 0 && !hold[k]) begin
                f         = srcq[k][0];
                vld_i[k]  = 1'b1;
                din[k]    = f[63:0];
                last_i[k] = f[64];
            end else begin
                vld_i[k]  = 1'b0;
                din[k]    = '0;
                last_i[k] = hold[k];   // last without valid must be ignored
            end
        end
        rdy_i = force_stall ? 1'b0 : (bp_mode ? bp_pat[cyc % 4] : 1'b1);
    endtask

    // One clock: sample/check at negedge, then update sources after posedge.
    task automatic tick();
        logic [3:0] acc;
        exp_t e;
        @(negedge clk);
        cyc++;
        s_vld = vld_o;
        s_src = src_id_o;
        check("rdy_other", 64'(rdy_o & ~(4'b0001 << src_id_o)), 64'd0);
        if (vld_o) check("rdy_mirror", 64'(rdy_o[src_id_o]), 64'(rdy_i));
        if (prev_stall && vld_o) begin
            check("stall_dout", dout, prev_dout);
            check("stall_src", 64'(src_id_o), 64'(prev_src));
        end
        check("trunc", 64'(trunc_o), 64'(pend_trunc));
        pend_trunc = 1'b0;
        if (vld_o && rdy_i) begin
            $display("beat cyc=%0d src=%0d data=%h last=%0d", cyc, src_id_o, dout, last_o);
            if (exp_q.size() == 0) begin
                check("extra_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("src", 64'(src_id_o), 64'(e.src));
                check("data", dout, e.data);
                check("last", 64'(last_o), 64'(e.last));
                pend_trunc = e.cut;
            end
            if (first_acc < 0) first_acc = cyc;
            if (chk_bubble && prev_last) check("bubble", 64'(cyc - last_acc), 64'd2);
            last_acc  = cyc;
            prev_last = last_o;
        end
        prev_stall = vld_o && !rdy_i;
        prev_dout  = dout;
        prev_src   = src_id_o;
        for (int k = 0; k < 4; k++) acc[k] = rdy_o[k] && vld_i[k];
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++)
            if (acc[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
        drive_inputs();
    endtask

    task automatic run_until_empty(input int budget);
        int n;
        int left;
        n = 0;
        left = exp_q.size() + srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size();
        while (left > 0 && n < budget) begin
            tick();
            n++;
            left = exp_q.size() + srcq[0].size() + srcq[1].size() + srcq[2].size() + srcq[3].size();
        end
        check("drain", 64'(left), 64'd0);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) srcq[k].delete();
        exp_q.delete();
        hold = '0;
        bp_mode = 1'b0;
        force_stall = 1'b0;
        drive_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_vld", 64'(vld_o), 64'd0);
        check("rst_rdy", 64'(rdy_o), 64'd0);
        check("rst_last", 64'(last_o), 64'd0);
        check("rst_trunc", 64'(trunc_o), 64'd0);
        check("rst_src", 64'(src_id_o), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive_inputs();
        pend_trunc = 1'b0;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        first_acc  = -1;
        chk_bubble = 1'b0;
    endtask

    initial begin
        int start;
        rst_n = 1'b0; vld_i = '0; din = '0; last_i = '0; rdy_i = 1'b0;
        hold = '0; bp_mode = 1'b0; force_stall = 1'b0; bp_pat = 4'b1001;
        pend_trunc = 1'b0; prev_stall = 1'b0; prev_last = 1'b0; chk_bubble = 1'b0;
        prev_dout = '0; prev_src = '0; first_acc = -1; last_acc = 0; s_vld = 1'b0; s_src = '0;

        // Single requester 2, 3-beat packet: one idle cycle, then beats in order.
        do_reset();
        start = cyc;
        src_pkt(2, 0, 3);
        exp_pkt(2, 0, 0, 2, 1'b1, 1'b0);
        drive_inputs();
        run_until_empty(50);
        check("s1_latency", 64'(first_acc - start), 64'd2);
        // Pointer is now 3: requester 3 must win over requester 0.
        src_pkt(0, 1, 2);
        src_pkt(3, 1, 2);
        exp_pkt(3, 1, 0, 1, 1'b1, 1'b0);
        exp_pkt(0, 1, 0, 1, 1'b1, 1'b0);
        drive_inputs();
        run_until_empty(50);

        // All four continuously valid: order 0,1,2,3,0,1,2,3 with one bubble each.
        do_reset();
        chk_bubble = 1'b1;
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 4; k++) begin
                src_pkt(k, p, 2);
                exp_pkt(k, p, 0, 1, 1'b1, 1'b0);
            end
        drive_inputs();
        run_until_empty(100);
        chk_bubble = 1'b0;

        // 20-beat packet from requester 1 is cut at 16; requester 2 slips in between.
        do_reset();
        src_pkt(1, 0, 20);
        src_pkt(2, 0, 2);
        exp_pkt(1, 0, 0, 15, 1'b1, 1'b1);
        exp_pkt(2, 0, 0, 1, 1'b1, 1'b0);
        exp_pkt(1, 0, 16, 19, 1'b1, 1'b0);
        drive_inputs();
        run_until_empty(100);

        // Backpressure 1,0,0,1 on requester 0.
        do_reset();
        bp_mode = 1'b1;
        src_pkt(0, 0, 4);
        exp_pkt(0, 0, 0, 3, 1'b1, 1'b0);
        drive_inputs();
        run_until_empty(60);
        bp_mode = 1'b0;

        // Requester 3 drops valid for 5 cycles mid-packet; requester 0 must wait.
        do_reset();
        src_pkt(3, 0, 4);
        exp_pkt(3, 0, 0, 3, 1'b1, 1'b0);
        exp_pkt(0, 0, 0, 1, 1'b1, 1'b0);
        drive_inputs();
        repeat (3) tick();
        src_pkt(0, 0, 2);
        hold[3] = 1'b1;
        drive_inputs();
        for (int i = 0; i < 5; i++) begin
            tick();
            check("gap_vld", 64'(s_vld), 64'd0);
            check("gap_src", 64'(s_src), 64'd3);
        end
        hold[3] = 1'b0;
        drive_inputs();
        run_until_empty(60);

        // Reset after beat 2 of 4: grant aborted, arbitration restarts from index 0.
        do_reset();
        src_pkt(1, 0, 2);
        exp_pkt(1, 0, 0, 1, 1'b1, 1'b0);
        drive_inputs();
        run_until_empty(30);
        src_pkt(2, 1, 4);
        exp_pkt(2, 1, 0, 1, 1'b0, 1'b0);
        drive_inputs();
        repeat (3) tick();
        rst_n = 1'b0;
        force_stall = 1'b1;
        drive_inputs();
        tick();
        rst_n = 1'b1;
        force_stall = 1'b0;
        src_pkt(0, 2, 2);
        exp_pkt(0, 2, 0, 1, 1'b1, 1'b0);
        exp_pkt(2, 1, 2, 3, 1'b1, 1'b0);
        drive_inputs();
        tick();
        check("rst_mid_idle", 64'(s_vld), 64'd0);
        run_until_empty(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
